buyruk_bellegi: RTL and testbench

Instruction-memory responder for the islemci core, serving the fetch side of the `ps` → `buyruk` interface. It adds a byte-serial program loader (valid/ready) that assembles little-endian words into the instruction array. After each load it fills every unwritten entry with NOP. While a load or clear is in progress it holds the core stalled through `cekirdek_beklet`.

---
 rtl/buyruk_bellegi_pkg.sv | 25 ++
 rtl/buyruk_bellegi_bayt_birlestirici.sv | 64 ++++++
 rtl/buyruk_bellegi.sv | 175 +++++++++++++++++
 tb/tb_buyruk_bellegi.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/buyruk_bellegi_pkg.sv
`default_nettype none
// ============================================================================
// Module : buyruk_bellegi_pkg
// Brief  : Shared definitions for the instruction memory and its loader.
//          Provides the NOP instruction word, the default memory depth and
//          the controller state encoding. The core bench uses these too.
// Rev    : 1.0 - initial release
// ============================================================================
package buyruk_bellegi_pkg;

  // Default number of 32-bit instruction words.
  localparam int DERINLIK_VARSAYILAN = 128;

  // ADDI x0,x0,0 : returned on error and used to fill unwritten entries.
  localparam logic [31:0] NOP_KOMUT = 32'h0000_0013;

  // Controller states: serve fetches, load program, fill remainder with NOP.
  typedef enum logic [1:0] {
    SUN     = 2'd0,
    YUKLE   = 2'd1,
    TEMIZLE = 2'd2
  } durum_t;

endpackage
`default_nettype wire

// File: rtl/buyruk_bellegi_bayt_birlestirici.sv
`default_nettype none
// ============================================================================
// Module : bayt_birlestirici
// Brief  : Byte-to-word assembler for the program loader. Bytes fill the
//          word little-endian (lane 0 = bits 7:0). A word is complete on the
//          fourth byte or on a byte flagged as last; unfilled lanes are 0.
// Ports  : clk, rst (async, active-low)
//          sifirla      - drop any partial word and restart at lane 0
//          al           - a loader byte is accepted this cycle
//          son          - the accepted byte is the last of the program
//          bayt         - loader data byte
//          kelime       - assembled word including the current byte
//          kelime_tamam - word complete this cycle (write strobe)
// Rev    : 1.0 - initial release
// ============================================================================
module bayt_birlestirici
  import buyruk_bellegi_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sifirla,
  input  logic        al,
  input  logic        son,
  input  logic [7:0]  bayt,
  output logic [31:0] kelime,
  output logic        kelime_tamam
);

  logic [1:0]  r_indeks;
  logic [31:0] r_birlesik;

  // Lanes above the current index are always zero in r_birlesik, so the
  // current byte is simply merged into its lane.
  always_comb begin
    kelime = r_birlesik;
    case (r_indeks)
      2'd0:    kelime[7:0]   = bayt;
      2'd1:    kelime[15:8]  = bayt;
      2'd2:    kelime[23:16] = bayt;
      default: kelime[31:24] = bayt;
    endcase
    kelime_tamam = al & ((r_indeks == 2'd3) | son);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_indeks   <= 2'd0;
      r_birlesik <= '0;
    end else if (sifirla) begin
      r_indeks   <= 2'd0;
      r_birlesik <= '0;
    end else if (al) begin
      if (kelime_tamam) begin
        r_indeks   <= 2'd0;
        r_birlesik <= '0;
      end else begin
        r_indeks   <= r_indeks + 2'd1;
        r_birlesik <= kelime;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/buyruk_bellegi.sv
`default_nettype none
// ============================================================================
// Module : buyruk_bellegi
// Brief  : Instruction memory for the islemci core with a byte-serial
//          program loader. Serves fetches with one-cycle latency, loads
//          little-endian words through a valid/ready byte stream, then fills
//          every unwritten entry with NOP while holding the core stalled.
// Ports  : clk, rst (async, active-low)
//          ps, istek                 - fetch address / request
//          buyruk, buyruk_gecerli,
//          hata                      - fetch result, valid pulse, error pulse
//          yukle_baslat              - start / restart a load
//          yukle_bayt, yukle_gecerli,
//          yukle_son, yukle_hazir    - loader byte stream
//          cekirdek_beklet           - stall request to the core
//          yuklenen_kelime           - words written by the last load
// Rev    : 1.0 - initial release
// ============================================================================
module buyruk_bellegi
  import buyruk_bellegi_pkg::*;
#(
  parameter int          DERINLIK = DERINLIK_VARSAYILAN,
  parameter logic [31:0] NOP      = NOP_KOMUT
)(
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 ps,
  input  logic                        istek,
  output logic [31:0]                 buyruk,
  output logic                        buyruk_gecerli,
  output logic                        hata,
  input  logic                        yukle_baslat,
  input  logic [7:0]                  yukle_bayt,
  input  logic                        yukle_gecerli,
  input  logic                        yukle_son,
  output logic                        yukle_hazir,
  output logic                        cekirdek_beklet,
  output logic [$clog2(DERINLIK):0]   yuklenen_kelime
);

  localparam int c_ADR_W = $clog2(DERINLIK);
  localparam int c_PTR_W = c_ADR_W + 1;
  localparam logic [c_PTR_W-1:0] c_SON_ADR = c_PTR_W'(DERINLIK - 1);
  localparam logic [c_PTR_W-1:0] c_DOLU    = c_PTR_W'(DERINLIK);

  durum_t               r_durum;
  logic [c_PTR_W-1:0]   r_ptr;
  logic [31:0]          r_mem [DERINLIK];

  logic                 w_al;
  logic [31:0]          w_kelime;
  logic                 w_kelime_tamam;
  logic                 w_yaz_en;
  logic [c_ADR_W-1:0]   w_yaz_adr;
  logic [31:0]          w_yaz_veri;
  logic                 w_hatali;
  logic [c_ADR_W-1:0]   w_oku_adr;

  // A byte offered in the same cycle as a restart is discarded: the restart
  // wins and the assembler starts again from lane 0.
  assign w_al = (r_durum == YUKLE) & yukle_gecerli & yukle_hazir & ~yukle_baslat;

  bayt_birlestirici u_birlestirici (
    .clk          (clk),
    .rst          (rst),
    .sifirla      (yukle_baslat),
    .al           (w_al),
    .son          (yukle_son),
    .bayt         (yukle_bayt),
    .kelime       (w_kelime),
    .kelime_tamam (w_kelime_tamam)
  );

  // Fetch decode: misaligned or beyond the array returns NOP with hata.
  assign w_hatali  = (|ps[1:0]) | (ps[31:2] >= 30'(DERINLIK));
  assign w_oku_adr = ps[c_ADR_W+1:2];

  // Single write port shared by the loader and the NOP fill.
  always_comb begin
    w_yaz_en   = 1'b0;
    w_yaz_adr  = r_ptr[c_ADR_W-1:0];
    w_yaz_veri = w_kelime;
    case (r_durum)
      YUKLE: begin
        w_yaz_en = w_kelime_tamam;
      end
      TEMIZLE: begin
        w_yaz_en   = ~yukle_baslat & (r_ptr < c_DOLU);
        w_yaz_veri = NOP;
      end
      default: begin
        w_yaz_en = 1'b0;
      end
    endcase
  end

  // Array contents survive reset, so the storage has no reset term.
  always_ff @(posedge clk) begin
    if (w_yaz_en) begin
      r_mem[w_yaz_adr] <= w_yaz_veri;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_durum         <= SUN;
      r_ptr           <= '0;
      buyruk          <= NOP;
      buyruk_gecerli  <= 1'b0;
      hata            <= 1'b0;
      yukle_hazir     <= 1'b0;
      cekirdek_beklet <= 1'b0;
      yuklenen_kelime <= '0;
    end else begin
      buyruk_gecerli <= 1'b0;
      hata           <= 1'b0;
      case (r_durum)
        SUN: begin
          if (yukle_baslat) begin
            r_durum         <= YUKLE;
            r_ptr           <= '0;
            yukle_hazir     <= 1'b1;
            cekirdek_beklet <= 1'b1;
          end else if (istek) begin
            buyruk_gecerli <= 1'b1;
            if (w_hatali) begin
              buyruk <= NOP;
              hata   <= 1'b1;
            end else begin
              buyruk <= r_mem[w_oku_adr];
            end
          end
        end

        YUKLE: begin
          if (yukle_baslat) begin
            r_ptr <= '0;
          end else if (w_kelime_tamam) begin
            r_ptr <= r_ptr + 1'b1;
            // Last byte, or the final entry just written, ends the load.
            if (yukle_son || (r_ptr == c_SON_ADR)) begin
              r_durum         <= TEMIZLE;
              yukle_hazir     <= 1'b0;
              yuklenen_kelime <= r_ptr + 1'b1;
            end
          end
        end

        TEMIZLE: begin
          if (yukle_baslat) begin
            r_durum     <= YUKLE;
            r_ptr       <= '0;
            yukle_hazir <= 1'b1;
          end else begin
            if (r_ptr != c_DOLU) begin
              r_ptr <= r_ptr + 1'b1;
            end
            // Leave together with the write of the final entry, or at once
            // when the load itself already filled the whole array.
            if (r_ptr >= c_SON_ADR) begin
              r_durum         <= SUN;
              cekirdek_beklet <= 1'b0;
            end
          end
        end

        default: begin
          r_durum <= SUN;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_buyruk_bellegi.sv
`default_nettype none
// ============================================================================
// Module : tb_buyruk_bellegi
// Brief  : Self-checking bench for buyruk_bellegi. Fetch results are
//          predicted from a word-array model of the program image and
//          queued; a monitor compares them whenever the DUT presents one.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_buyruk_bellegi;

  localparam int          D    = 128;
  localparam logic [31:0] NOPW = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ps = '0;
  logic        istek = 1'b0;
  logic [31:0] buyruk;
  logic        buyruk_gecerli;
  logic        hata;
  logic        yukle_baslat = 1'b0;
  logic [7:0]  yukle_bayt = '0;
  logic        yukle_gecerli = 1'b0;
  logic        yukle_son = 1'b0;
  logic        yukle_hazir;
  logic        cekirdek_beklet;
  logic [7:0]  yuklenen_kelime;

  always #5 clk = ~clk;

  buyruk_bellegi dut (
    .clk             (clk),
    .rst             (rst),
    .ps              (ps),
    .istek           (istek),
    .buyruk          (buyruk),
    .buyruk_gecerli  (buyruk_gecerli),
    .hata            (hata),
    .yukle_baslat    (yukle_baslat),
    .yukle_bayt      (yukle_bayt),
    .yukle_gecerli   (yukle_gecerli),
    .yukle_son       (yukle_son),
    .yukle_hazir     (yukle_hazir),
    .cekirdek_beklet (cekirdek_beklet),
    .yuklenen_kelime (yuklenen_kelime)
  );

  typedef struct {
    logic [31:0] veri;
    logic        hata;
    longint      due;
  } bek_t;

  bek_t        sb[$];
  bek_t        mon_e;
  logic [31:0] ref_mem [D];
  int          gecen  = 0;
  int          toplam = 0;
  longint      cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
    toplam++;
    if (gercek === beklenen) gecen++;
    else $display("FAIL %s: actual=%h required=%h (t=%0t)", ad, gercek, beklenen, $time);
  endfunction

  function automatic void kontrol1(input string ad, input logic gercek, input logic beklenen);
    toplam++;
    if (gercek === beklenen) gecen++;
    else $display("FAIL %s: actual=%b required=%b (t=%0t)", ad, gercek, beklenen, $time);
  endfunction

  // Monitor: every valid pulse must match the oldest queued prediction and
  // arrive exactly on its due cycle; no pulse may appear unannounced.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (buyruk_gecerli === 1'b1) begin
        if (sb.size() == 0) begin
          toplam++;
          $display("FAIL beklenmeyen_gecerli: actual=1 required=0 (t=%0t)", $time);
        end else begin
          mon_e = sb.pop_front();
          kontrol("gecikme", 32'(cyc), 32'(mon_e.due));
          kontrol("buyruk", buyruk, mon_e.veri);
          kontrol1("hata", hata, mon_e.hata);
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        mon_e = sb.pop_front();
        kontrol1("gecerli_eksik", buyruk_gecerli, 1'b1);
      end
    end
  end

  // Program image after a load: words packed little-endian from the byte
  // list, entries from the word count up to dolgu_son become NOP.
  function automatic int model_yukle(input logic [7:0] b[$], input int dolgu_son);
    int n;
    logic [31:0] w;
    n = (b.size() + 3) / 4;
    if (n > D) n = D;
    for (int i = 0; i < n; i++) begin
      w = '0;
      for (int j = 0; j < 4; j++)
        if (4 * i + j < b.size()) w[8*j +: 8] = b[4*i+j];
      ref_mem[i] = w;
    end
    for (int i = n; i < dolgu_son; i++) ref_mem[i] = NOPW;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic getir(input logic [31:0] a);
    bek_t e;
    istek = 1'b1;
    ps    = a;
    if (a[1:0] != 2'b00 || (a >> 2) >= D) begin
      e.veri = NOPW;
      e.hata = 1'b1;
    end else begin
      e.veri = ref_mem[a >> 2];
      e.hata = 1'b0;
    end
    e.due = cyc + 1;
    sb.push_back(e);
    tick();
    istek = 1'b0;
  endtask

  task automatic bosalt();
    repeat (2) tick();
    kontrol("sb_bos", 32'(sb.size()), 32'd0);
  endtask

  // A fetch may accompany the start; it must be dropped.
  task automatic basla();
    yukle_baslat = 1'b1;
    istek        = 1'($urandom_range(0, 1));
    ps           = 32'h0;
    tick();
    yukle_baslat = 1'b0;
    istek        = 1'b0;
    kontrol1("hazir_yukle", yukle_hazir, 1'b1);
    kontrol1("beklet_yukle", cekirdek_beklet, 1'b1);
  endtask

  task automatic bayt_gonder(input logic [7:0] b, input logic son);
    int bosluk;
    bosluk = $urandom_range(0, 2);
    repeat (bosluk) begin
      yukle_gecerli = 1'b0;
      istek         = 1'($urandom_range(0, 1));
      ps            = 32'($urandom_range(0, D - 1)) << 2;
      tick();
    end
    yukle_gecerli = 1'b1;
    yukle_bayt    = b;
    yukle_son     = son;
    istek         = 1'($urandom_range(0, 1));
    tick();
    yukle_gecerli = 1'b0;
    yukle_son     = 1'b0;
    istek         = 1'b0;
  endtask

  task automatic yukle_program(input logic [7:0] b[$], input logic son_ver);
    basla();
    for (int i = 0; i < b.size(); i++)
      bayt_gonder(b[i], son_ver && (i == b.size() - 1));
  endtask

  // Called right after the edge that ended the load; counts fill cycles
  // until the stall is released.
  task automatic bitis_bekle(input int n);
    int k;
    int bek_k;
    k     = 0;
    bek_k = (D - n > 1) ? D - n : 1;
    kontrol("yuklenen_kelime", 32'(yuklenen_kelime), 32'(n));
    kontrol1("hazir_temizle", yukle_hazir, 1'b0);
    kontrol1("beklet_temizle", cekirdek_beklet, 1'b1);
    while (cekirdek_beklet === 1'b1 && k < 600) begin
      tick();
      k++;
    end
    kontrol("temizle_cevrim", 32'(k), 32'(bek_k));
  endtask

  task automatic sifir_kontrol(input string ad);
    kontrol({ad, "_buyruk"}, buyruk, NOPW);
    kontrol1({ad, "_gecerli"}, buyruk_gecerli, 1'b0);
    kontrol1({ad, "_hata"}, hata, 1'b0);
    kontrol1({ad, "_hazir"}, yukle_hazir, 1'b0);
    kontrol1({ad, "_beklet"}, cekirdek_beklet, 1'b0);
    kontrol({ad, "_yuklenen"}, 32'(yuklenen_kelime), 32'd0);
  endtask

  task automatic rastgele_tur();
    logic [7:0]  b[$];
    int          len;
    int          n;
    logic [31:0] a;
    len = $urandom_range(1, 40);
    if ($urandom_range(0, 2) == 0) begin
      basla();
      repeat ($urandom_range(1, 9)) bayt_gonder(8'($urandom), 1'b0);
    end
    b = {};
    for (int i = 0; i < len; i++) b.push_back(8'($urandom));
    yukle_program(b, 1'b1);
    n = model_yukle(b, D);
    bitis_bekle(n);
    for (int f = 0; f < 10; f++) begin
      case ($urandom_range(0, 5))
        0:       a = (32'($urandom_range(0, D - 1)) << 2) + 32'($urandom_range(1, 3));
        1:       a = 32'($urandom_range(D, 4 * D)) << 2;
        default: a = 32'($urandom_range(0, D - 1)) << 2;
      endcase
      getir(a);
    end
    bosalt();
  endtask

  initial begin
    logic [7:0] b[$];
    int         n;

    // Reset state
    #1 rst = 1'b0;
    #2;
    sifir_kontrol("reset");
    @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // Two-word program, NOP fill of the remainder
    b = '{8'h13, 8'h03, 8'h43, 8'h01, 8'h93, 8'h82, 8'h62, 8'hFF};
    yukle_program(b, 1'b1);
    n = model_yukle(b, D);
    bitis_bekle(n);

    // Fetches, including back-to-back
    getir(32'd4);
    getir(32'd0);
    getir(32'd4);
    getir(32'd8);
    bosalt();

    // Error fetches and the last valid entry
    getir(32'd6);
    getir(32'd512);
    getir(32'd508);
    getir(32'hFFFF_FFFC);
    bosalt();

    // Partial word
    b = '{8'hAA, 8'hBB};
    yukle_program(b, 1'b1);
    n = model_yukle(b, D);
    bitis_bekle(n);
    getir(32'd0);
    getir(32'd4);
    bosalt();

    // Restart mid-load
    basla();
    repeat (5) bayt_gonder(8'($urandom), 1'b0);
    b = '{8'h67, 8'h80, 8'h00, 8'h00};
    yukle_program(b, 1'b1);
    n = model_yukle(b, D);
    bitis_bekle(n);
    getir(32'd0);
    getir(32'd4);
    bosalt();

    // Randomized programs
    for (int it = 0; it < 6; it++) rastgele_tur();

    // Full array: load ends implicitly on the last entry
    b = {};
    for (int i = 0; i < 4 * D; i++) b.push_back(8'($urandom));
    yukle_program(b, 1'b0);
    n = model_yukle(b, D);
    bitis_bekle(n);
    getir(32'((D - 1) * 4));
    getir(32'd160);
    bosalt();

    // Reset while filling, with the fill pointer at 40
    b = {};
    for (int i = 0; i < 8; i++) b.push_back(8'($urandom));
    yukle_program(b, 1'b1);
    repeat (38) tick();
    rst = 1'b0;
    #1;
    sifir_kontrol("reset_temizle");
    n = model_yukle(b, 40);
    #2 rst = 1'b1;
    tick();
    kontrol1("sun_hazir", yukle_hazir, 1'b0);
    kontrol1("sun_beklet", cekirdek_beklet, 1'b0);
    getir(32'd0);
    getir(32'd4);
    getir(32'd156);
    getir(32'd160);
    bosalt();

    $display("%0d/%0d checks passed", gecen, toplam);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
